answer_gen: RTL
===============

Name: answer_gen

Overview:
- Parametrised answer generator for the number-guessing game.
- Draws DIGITS values in 1..RANGE from a free-running 32-bit LCG; in UNIQUE mode, duplicates are rejected and redrawn.
- Delivers the finished answer with a one-cycle valid pulse to the answer register/write port.
- Adds over the previous generator: seed loading, multi-digit output, uniqueness, a busy/valid handshake, a bounded draw count with deterministic fallback, and proper reset.

Parameters:
- DIGITS, 3, number of answer digits (1..RANGE).
- RANGE, 9, digits drawn from 1..RANGE (2..15).
- UNIQUE, 1, 1 = all digits distinct (rejection sampling); 0 = repeats allowed.
- MAX_TRIES, 16, DRAW cycles allowed before fallback fill (>= DIGITS).
- LCG_A, 1103515245, LCG multiplier.
- LCG_C, 12345, LCG increment.

Ports:
- clk  in  1  system clock, all logic on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- seed_load  in  1  load seed into LCG state this cycle.
- seed  in  32  seed value.
- req  in  1  request new answer; sampled only in IDLE.
- busy  out  1  high while generating.
- valid  out  1  one-cycle pulse: answer updated.
- answer  out  4*DIGITS  digit i in bits [4i+3:4i], digit 0 at LSB; 0 = no answer yet.

Behaviour:
- One clock (clk); reset is asynchronous and active-low (rst_n). Polarity and synchronicity are fixed.
- Reset values: LCG state s=1, state IDLE, busy=0, valid=0, answer=0, counters 0.
- LCG: s <= LCG_A*s + LCG_C mod 2^32 every cycle in all states. seed_load has priority: s <= seed. A seed_load during DRAW does not abort the draw; later candidates use the new sequence.
- Candidate (combinational): cand = (s[30:16] % RANGE) + 1, using the current s.
- FSM IDLE:
  - req=1 -> DRAW; clear idx, tries, work register; busy=1 from the next cycle.
  - req=1 in any other state is ignored, not queued.
- FSM DRAW (one candidate per cycle):
  - If UNIQUE=0, or cand differs from all work digits 0..idx-1: store at work[idx], idx++.
  - Otherwise reject; idx unchanged.
  - tries++ every DRAW cycle.
  - Completion: if this cycle stores digit DIGITS-1, then answer <= work incl. cand, valid <= 1, busy <= 0, -> IDLE.
  - Fallback: else if tries == MAX_TRIES-1 -> FILL.
- FSM FILL (UNIQUE=1 only, unreachable otherwise):
  - Each cycle, store the smallest value in 1..RANGE not present in work[0..idx-1]; idx++.
  - After the last digit: commit as in DRAW (answer, valid, busy, -> IDLE).
- Latency:
  - req sampled at edge 0 with no rejections -> valid high in the cycle after edge DIGITS.
  - Worst case: MAX_TRIES + DIGITS-1 cycles.
- valid is exactly one cycle. A req in that same cycle (state is IDLE) starts a new generation.
- answer holds its value between valid pulses; it never shows partial results.
- rst_n asserted mid-generation: immediate return to reset values; the in-progress answer is discarded.
- Widths: digits are 4 bits; idx/tries counters are sized by $clog2 of their limits; the multiply is truncated to 32 bits.
- Elaboration check: DIGITS > RANGE with UNIQUE=1 is an error.

Decomposition:
- Package answer_gen_pkg holds:
  - DIGIT_W=4
  - default LCG_A/LCG_C
  - FSM state enum {IDLE, DRAW, FILL}
- One sub-module: lcg_core (params A, C; ports clk, rst_n, load, seed, state[31:0]) implementing the step/load/reset logic.
- answer_gen instantiates lcg_core and holds the FSM, duplicate comparators, and fill priority encoder.

Test Plan:
- Reset mid-generation: assert rst_n=0 two cycles after req -> answer=0x000, valid=0, busy=0, IDLE; the next req works normally.
- Fallback fill: LCG_A=1, LCG_C=0, seed=0x0005_0000 (cand always 6), MAX_TRIES=16, req at edge 0:
  - work[0]=6, then 15 rejects, FILL fills 1 then 2.
  - valid after edge 18; answer=0x216.
- Reproducibility and uniqueness: default params, seed=0x1234_5678, req twice with a reseed before each.
  - Both answers are identical.
  - Every digit lies in 1..9; all distinct.
  - valid is one cycle; busy=0 in the valid cycle.
- Busy ignores req: pulse req every cycle for 40 cycles -> valid pulses spaced >= DIGITS+1 cycles apart; no lost or extra handshakes; answer only changes on valid.
- UNIQUE=0, LCG_A=1, LCG_C=0, seed=0x0005_0000 -> answer=0x666 after exactly 3 DRAW cycles; FILL never entered.
- seed_load during DRAW -> generation completes; subsequent candidates follow the new seed sequence; uniqueness holds.

Source files
------------

// File: rtl/answer_gen_pkg.sv
// Shared types and constants for the number-guessing answer generator.
package answer_gen_pkg;
  localparam int unsigned DIGIT_W   = 4;
  localparam logic [31:0] LCG_A_DEF = 32'd1103515245;
  localparam logic [31:0] LCG_C_DEF = 32'd12345;

  typedef enum logic [1:0] {IDLE, DRAW, FILL} state_e;
endpackage

// File: rtl/lcg_core.sv
// Free-running 32-bit linear congruential generator with synchronous seed load.
module lcg_core
  import answer_gen_pkg::*;
#(
  parameter logic [31:0] A = LCG_A_DEF,
  parameter logic [31:0] C = LCG_C_DEF
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load,
  input  logic [31:0] seed,
  output logic [31:0] state
);
  logic [31:0] s_q, s_d;

  always_comb begin
    s_d = load ? seed : A * s_q + C;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) s_q <= 32'd1;
    else        s_q <= s_d;
  end

  assign state = s_q;
endmodule

// File: rtl/answer_gen.sv
// Draws DIGITS values in 1..RANGE from the LCG, optionally distinct, and
// publishes the finished answer with a one-cycle valid pulse.
module answer_gen
  import answer_gen_pkg::*;
#(
  parameter int unsigned DIGITS    = 3,
  parameter int unsigned RANGE     = 9,
  parameter int unsigned UNIQUE    = 1,
  parameter int unsigned MAX_TRIES = 16,
  parameter logic [31:0] LCG_A     = LCG_A_DEF,
  parameter logic [31:0] LCG_C     = LCG_C_DEF
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        seed_load,
  input  logic [31:0]                 seed,
  input  logic                        req,
  output logic                        busy,
  output logic                        valid,
  output logic [DIGIT_W*DIGITS-1:0]   answer
);
  localparam int unsigned      IDX_W    = $clog2(DIGITS + 1);
  localparam int unsigned      TRY_W    = $clog2(MAX_TRIES + 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DIGITS - 1);
  localparam logic [TRY_W-1:0] TRY_LAST = TRY_W'(MAX_TRIES - 1);

  typedef logic [DIGITS-1:0][DIGIT_W-1:0] work_t;

  if (UNIQUE != 0 && DIGITS > RANGE) begin : g_bad_cfg
    $error("answer_gen: DIGITS exceeds RANGE with UNIQUE set");
  end

  logic [31:0]        s_q;
  logic               unused_s;
  state_e             state_q, state_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [TRY_W-1:0]   tries_q, tries_d;
  work_t              work_q, work_d, answer_q, answer_d;
  logic               busy_q, busy_d, valid_q, valid_d;
  logic [14:0]        cand_mod;
  logic [DIGIT_W-1:0] cand, fill_val, store_val;
  logic               dup, store;

  lcg_core #(.A(LCG_A), .C(LCG_C)) u_lcg (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (seed_load),
    .seed  (seed),
    .state (s_q)
  );

  assign unused_s = ^{s_q[31], s_q[15:0]};

  // Candidate, duplicate compare against the filled prefix, and smallest free value.
  always_comb begin
    logic taken;
    cand_mod = s_q[30:16] % 15'(RANGE);
    cand     = 4'(cand_mod) + 4'd1;
    dup      = 1'b0;
    for (int unsigned i = 0; i < DIGITS; i++) begin
      if (i < 32'(idx_q) && work_q[i] == cand) dup = 1'b1;
    end
    fill_val = '0;
    taken    = 1'b0;
    for (int unsigned v = RANGE; v >= 1; v--) begin
      taken = 1'b0;
      for (int unsigned i = 0; i < DIGITS; i++) begin
        if (i < 32'(idx_q) && work_q[i] == 4'(v)) taken = 1'b1;
      end
      if (!taken) fill_val = 4'(v);
    end
  end

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    tries_d   = tries_q;
    work_d    = work_q;
    answer_d  = answer_q;
    busy_d    = busy_q;
    valid_d   = 1'b0;
    store     = 1'b0;
    store_val = cand;
    unique case (state_q)
      IDLE: begin
        if (req) begin
          state_d = DRAW;
          idx_d   = '0;
          tries_d = '0;
          work_d  = '0;
          busy_d  = 1'b1;
        end
      end
      DRAW: begin
        tries_d = tries_q + TRY_W'(1);
        store   = (UNIQUE == 0) || !dup;
        if (!(store && idx_q == IDX_LAST) && tries_q == TRY_LAST) state_d = FILL;
      end
      FILL: begin
        store     = 1'b1;
        store_val = fill_val;
      end
      default: state_d = IDLE;
    endcase
    // Completion overrides the fallback transition computed above.
    if (store) begin
      for (int unsigned i = 0; i < DIGITS; i++) begin
        if (i == 32'(idx_q)) work_d[i] = store_val;
      end
      idx_d = idx_q + IDX_W'(1);
      if (idx_q == IDX_LAST) begin
        answer_d = work_d;
        valid_d  = 1'b1;
        busy_d   = 1'b0;
        state_d  = IDLE;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      idx_q    <= '0;
      tries_q  <= '0;
      work_q   <= '0;
      answer_q <= '0;
      busy_q   <= 1'b0;
      valid_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      tries_q  <= tries_d;
      work_q   <= work_d;
      answer_q <= answer_d;
      busy_q   <= busy_d;
      valid_q  <= valid_d;
    end
  end

  assign busy   = busy_q;
  assign valid  = valid_q;
  assign answer = answer_q;
endmodule
